// File: rtl/periph_pkg.sv
// Shared definitions for the board peripherals: address map, LCD strobe
// states and the byte-enable merge used by every writable register.
package periph_pkg;

    localparam logic [7:0] ADDR_LEDR     = 8'h00;
    localparam logic [7:0] ADDR_LEDG     = 8'h10;
    localparam logic [7:0] ADDR_HEX_LO   = 8'h20;
    localparam logic [7:0] ADDR_HEX_HI   = 8'h24;
    localparam logic [7:0] ADDR_LCD      = 8'h30;
    localparam logic [7:0] ADDR_LCD_STAT = 8'h34;
    localparam logic [7:0] ADDR_SW       = 8'h40;
    localparam logic [7:0] ADDR_BTN      = 8'h44;

    // Bits of the HEX words and LCD command word that actually exist in hardware.
    localparam logic [31:0] HEX_MASK     = 32'h7F7F_7F7F;
    localparam logic [31:0] HEX_RESET    = 32'h7F7F_7F7F;
    localparam logic [31:0] LCD_CMD_MASK = 32'h8000_03FF;

    typedef enum logic [1:0] {
        LCD_IDLE  = 2'd0,
        LCD_SETUP = 2'd1,
        LCD_PULSE = 2'd2,
        LCD_HOLD  = 2'd3
    } lcd_state_e;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/output_peri_if.sv
// Load-store unit side of the output peripheral: word write port plus
// combinational read-back on the shared address.
interface output_peri_if;
    logic [7:0]  addr;
    logic        wr_en;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] rdata;

    // wr_en is a single-cycle strobe with no back-pressure: every asserted
    // cycle is one store, sampled on the rising clk edge.
    modport master (output addr, output wr_en, output wmask, output wdata, input rdata);
    modport slave  (input addr, input wr_en, input wmask, input wdata, output rdata);
endinterface

// File: rtl/lcd_strobe.sv
// Character-LCD enable sequencer: SETUP (en low), PULSE (en high), HOLD
// (en low), each timed by one down-counter reloaded on state entry.
module lcd_strobe
    import periph_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 12,
    parameter int HOLD_CYC  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    output logic       en_o,
    output logic       busy_o,
    output lcd_state_e state_o
);

    localparam int MAX_A = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_C = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
    localparam int CW    = $clog2(MAX_C + 1);

    lcd_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          en_q;
    logic          busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LCD_IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                LCD_IDLE: begin
                    if (start_i) begin
                        state_q <= LCD_SETUP;
                        cnt_q   <= CW'(SETUP_CYC - 1);
                        busy_q  <= 1'b1;
                    end
                end
                LCD_SETUP: begin
                    if (cnt_q == '0) begin
                        state_q <= LCD_PULSE;
                        cnt_q   <= CW'(PULSE_CYC - 1);
                        en_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                LCD_PULSE: begin
                    if (cnt_q == '0) begin
                        state_q <= LCD_HOLD;
                        cnt_q   <= CW'(HOLD_CYC - 1);
                        en_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    if (cnt_q == '0) begin
                        state_q <= LCD_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
            endcase
        end
    end

    assign en_o    = en_q;
    assign busy_o  = busy_q;
    assign state_o = state_q;

endmodule

// File: rtl/output_peri.sv
// Board output register file (LEDs, 7-segment digits, LCD bus) with
// byte-masked writes, combinational read-back and LCD strobe launch.
module output_peri
    import periph_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 12,
    parameter int HOLD_CYC  = 2
) (
    input  logic          clk,
    input  logic          rst,
    output_peri_if.slave  bus,
    output logic [31:0]   o_ledr,
    output logic [31:0]   o_ledg,
    output logic [6:0]    o_hex0,
    output logic [6:0]    o_hex1,
    output logic [6:0]    o_hex2,
    output logic [6:0]    o_hex3,
    output logic [6:0]    o_hex4,
    output logic [6:0]    o_hex5,
    output logic [6:0]    o_hex6,
    output logic [6:0]    o_hex7,
    output logic [31:0]   o_lcd,
    output lcd_state_e    lcd_state_o
);

    logic [31:0] ledr_q, ledr_d;
    logic [31:0] ledg_q, ledg_d;
    logic [31:0] hex_lo_q, hex_lo_d;
    logic [31:0] hex_hi_q, hex_hi_d;
    logic [31:0] cmd_q, cmd_d;
    logic        overrun_q, overrun_d;

    logic sel_ledr, sel_ledg, sel_hex_lo, sel_hex_hi, sel_lcd, sel_stat;
    logic cmd_wr, lcd_start, lcd_en, lcd_busy;
    logic unused_addr;

    assign unused_addr = ^bus.addr[1:0];

    always_comb begin
        sel_ledr   = bus.wr_en && (bus.addr[7:2] == ADDR_LEDR[7:2]);
        sel_ledg   = bus.wr_en && (bus.addr[7:2] == ADDR_LEDG[7:2]);
        sel_hex_lo = bus.wr_en && (bus.addr[7:2] == ADDR_HEX_LO[7:2]);
        sel_hex_hi = bus.wr_en && (bus.addr[7:2] == ADDR_HEX_HI[7:2]);
        sel_lcd    = bus.wr_en && (bus.addr[7:2] == ADDR_LCD[7:2]);
        sel_stat   = bus.wr_en && (bus.addr[7:2] == ADDR_LCD_STAT[7:2]);

        ledr_d   = sel_ledr   ? merge_bytes(ledr_q, bus.wdata, bus.wmask) : ledr_q;
        ledg_d   = sel_ledg   ? merge_bytes(ledg_q, bus.wdata, bus.wmask) : ledg_q;
        hex_lo_d = sel_hex_lo ? (merge_bytes(hex_lo_q, bus.wdata, bus.wmask) & HEX_MASK) : hex_lo_q;
        hex_hi_d = sel_hex_hi ? (merge_bytes(hex_hi_q, bus.wdata, bus.wmask) & HEX_MASK) : hex_hi_q;

        // A command arriving while a strobe is in flight is dropped whole.
        cmd_wr    = sel_lcd && (bus.wmask != 4'd0);
        lcd_start = cmd_wr && !lcd_busy;
        cmd_d     = lcd_start ? (merge_bytes(cmd_q, bus.wdata, bus.wmask) & LCD_CMD_MASK) : cmd_q;

        overrun_d = overrun_q;
        if (sel_stat && bus.wmask[0]) overrun_d = 1'b0;
        if (cmd_wr && lcd_busy)       overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ledr_q    <= '0;
            ledg_q    <= '0;
            hex_lo_q  <= HEX_RESET;
            hex_hi_q  <= HEX_RESET;
            cmd_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            ledr_q    <= ledr_d;
            ledg_q    <= ledg_d;
            hex_lo_q  <= hex_lo_d;
            hex_hi_q  <= hex_hi_d;
            cmd_q     <= cmd_d;
            overrun_q <= overrun_d;
        end
    end

    lcd_strobe #(
        .SETUP_CYC (SETUP_CYC),
        .PULSE_CYC (PULSE_CYC),
        .HOLD_CYC  (HOLD_CYC)
    ) u_lcd_strobe (
        .clk     (clk),
        .rst     (rst),
        .start_i (lcd_start),
        .en_o    (lcd_en),
        .busy_o  (lcd_busy),
        .state_o (lcd_state_o)
    );

    always_comb begin
        case (bus.addr[7:2])
            ADDR_LEDR[7:2]:     bus.rdata = ledr_q;
            ADDR_LEDG[7:2]:     bus.rdata = ledg_q;
            ADDR_HEX_LO[7:2]:   bus.rdata = hex_lo_q;
            ADDR_HEX_HI[7:2]:   bus.rdata = hex_hi_q;
            ADDR_LCD[7:2]:      bus.rdata = cmd_q;
            ADDR_LCD_STAT[7:2]: bus.rdata = {30'd0, overrun_q, lcd_busy};
            default:            bus.rdata = '0;
        endcase
    end

    assign o_ledr = ledr_q;
    assign o_ledg = ledg_q;
    assign o_hex0 = hex_lo_q[6:0];
    assign o_hex1 = hex_lo_q[14:8];
    assign o_hex2 = hex_lo_q[22:16];
    assign o_hex3 = hex_lo_q[30:24];
    assign o_hex4 = hex_hi_q[6:0];
    assign o_hex5 = hex_hi_q[14:8];
    assign o_hex6 = hex_hi_q[22:16];
    assign o_hex7 = hex_hi_q[30:24];
    assign o_lcd  = {cmd_q[31], 20'd0, lcd_en, cmd_q[9:0]};

endmodule

// File: tb/tb_output_peri.sv
// Self-checking bench for output_peri: register writes/readback, LCD strobe
// timing, overrun handling, reset abort and unmapped addresses.
module tb_output_peri;
    import periph_pkg::*;

    localparam int S = 2;
    localparam int P = 12;
    localparam int H = 2;

    logic        clk;
    logic        rst;
    logic [31:0] ledr, ledg, lcd;
    logic [6:0]  hex [8];
    lcd_state_e  lcd_state;

    output_peri_if bus ();

    output_peri #(.SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_ledr      (ledr),
        .o_ledg      (ledg),
        .o_hex0      (hex[0]),
        .o_hex1      (hex[1]),
        .o_hex2      (hex[2]),
        .o_hex3      (hex[3]),
        .o_hex4      (hex[4]),
        .o_hex5      (hex[5]),
        .o_hex6      (hex[6]),
        .o_hex7      (hex[7]),
        .o_lcd       (lcd),
        .lcd_state_o (lcd_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // Scoreboard
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop_check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected <queue empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, obs, e);
        end
    endtask

    // Drivers
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        bus.addr  = a;
        bus.wdata = d;
        bus.wmask = m;
        bus.wr_en = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.wmask = 4'd0;
    endtask

    task automatic bus_read_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        @(negedge clk);
        bus.addr = a;
        #1;
        sb_pop_check(tag, bus.rdata);
    endtask

    function automatic logic [31:0] model_merge(input logic [31:0] o, input logic [31:0] n,
                                                input logic [3:0] m);
        logic [31:0] bm;
        bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        return (n & bm) | (o & ~bm);
    endfunction

    logic [31:0] ledg_model;
    logic [31:0] rd, rm;
    logic [3:0]  rmask;
    logic        done;

    initial begin
        rst       = 1'b1;
        bus.addr  = 8'h00;
        bus.wr_en = 1'b0;
        bus.wmask = 4'd0;
        bus.wdata = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        #1;
        for (int i = 0; i < 8; i++) check_eq($sformatf("reset_hex%0d", i), 32'(hex[i]), 32'h7F);
        check_eq("reset_lcd_port", lcd, 32'h0);
        check_eq("reset_state", 32'(lcd_state), 32'(LCD_IDLE));
        bus_read_check("reset_ledr", ADDR_LEDR, 32'h0);
        bus_read_check("reset_ledg", ADDR_LEDG, 32'h0);
        bus_read_check("reset_hex_lo", ADDR_HEX_LO, 32'h7F7F7F7F);
        bus_read_check("reset_hex_hi", ADDR_HEX_HI, 32'h7F7F7F7F);
        bus_read_check("reset_lcd", ADDR_LCD, 32'h0);
        bus_read_check("reset_stat", ADDR_LCD_STAT, 32'h0);

        // Byte-masked LED writes
        bus_write(ADDR_LEDR, 32'hDEADBEEF, 4'b0101);
        #1;
        check_eq("ledr_port", ledr, 32'h00AD00EF);
        bus_read_check("ledr_rd", ADDR_LEDR, 32'h00AD00EF);

        ledg_model = 32'h0;
        for (int i = 0; i < 4; i++) begin
            rd    = $urandom;
            rmask = 4'($urandom_range(0, 15));
            ledg_model = model_merge(ledg_model, rd, rmask);
            bus_write(ADDR_LEDG, rd, rmask);
            exp_q.push_back(ledg_model);
            #1;
            sb_pop_check($sformatf("ledg_port_%0d", i), ledg);
            bus_read_check($sformatf("ledg_rd_%0d", i), ADDR_LEDG, ledg_model);
        end

        // HEX digits, bit 7 dropped
        bus_write(ADDR_HEX_LO, 32'h40792430, 4'hF);
        #1;
        check_eq("hex0", 32'(hex[0]), 32'h30);
        check_eq("hex1", 32'(hex[1]), 32'h24);
        check_eq("hex2", 32'(hex[2]), 32'h79);
        check_eq("hex3", 32'(hex[3]), 32'h40);
        bus_read_check("hex_lo_rd", ADDR_HEX_LO, 32'h40792430);
        bus_write(ADDR_HEX_HI, 32'hFF80_00FF, 4'b1011);
        #1;
        check_eq("hex4_bit7", 32'(hex[4]), 32'h7F);
        check_eq("hex5", 32'(hex[5]), 32'h00);
        check_eq("hex6_unmasked", 32'(hex[6]), 32'h7F);
        bus_read_check("hex_hi_rd", ADDR_HEX_HI, 32'h7F7F007F);

        // LCD command and strobe timing; first sample is cycle N+1
        bus_write(ADDR_LCD, 32'h80000141, 4'hF);
        for (int k = 1; k <= 20; k++) begin
            exp_q.push_back({30'd0, 1'(k <= S + P + H), 1'(k >= S + 1 && k <= S + P)});
        end
        for (int k = 1; k <= 20; k++) begin
            bus.addr = ADDR_LCD_STAT;
            #1;
            sb_pop_check($sformatf("lcd_seq_c%0d", k), {30'd0, bus.rdata[0], lcd[10]});
            check_eq($sformatf("lcd_fields_c%0d", k), lcd & ~32'h400, 32'h80000141);
            @(negedge clk);
        end

        // Overrun: second command 5 cycles into a sequence
        bus_write(ADDR_LCD, 32'h80000141, 4'hF);
        repeat (3) @(negedge clk);
        bus_write(ADDR_LCD, 32'h00000222, 4'hF);
        #1;
        check_eq("ovr_lcd_port", lcd & ~32'h400, 32'h80000141);
        bus_read_check("ovr_lcd_rd", ADDR_LCD, 32'h80000141);
        bus_read_check("ovr_stat", ADDR_LCD_STAT, 32'h3);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            bus.addr = ADDR_LCD_STAT;
            #1;
            if (bus.rdata[0] == 1'b0) done = 1'b1;
        end
        check_eq("ovr_idle_wait", 32'(done), 32'h1);
        bus_read_check("ovr_stat_idle", ADDR_LCD_STAT, 32'h2);
        bus_write(ADDR_LCD_STAT, 32'h1, 4'b0001);
        bus_read_check("ovr_cleared", ADDR_LCD_STAT, 32'h0);

        // Reset during PULSE aborts the strobe
        bus_write(ADDR_LCD, 32'h80000141, 4'hF);
        repeat (5) @(negedge clk);
        #1;
        check_eq("pre_rst_en", 32'(lcd[10]), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.addr = ADDR_LCD_STAT;
        #1;
        check_eq("rst_lcd_port", lcd, 32'h0);
        check_eq("rst_state", 32'(lcd_state), 32'(LCD_IDLE));
        check_eq("rst_stat", bus.rdata, 32'h0);
        bus_write(ADDR_LCD, 32'h00000155, 4'hF);
        #1;
        check_eq("post_rst_state", 32'(lcd_state), 32'(LCD_SETUP));
        check_eq("post_rst_lcd", lcd, 32'h00000155);
        bus_read_check("post_rst_busy", ADDR_LCD_STAT, 32'h1);

        // Unmapped address
        bus_write(8'h50, 32'hFFFFFFFF, 4'hF);
        #1;
        check_eq("unmapped_ledr", ledr, 32'h0);
        check_eq("unmapped_ledg", ledg, 32'h0);
        check_eq("unmapped_hex0", 32'(hex[0]), 32'h7F);
        bus_read_check("unmapped_rd", 8'h50, 32'h0);
        bus_read_check("unmapped_hex_rd", ADDR_HEX_LO, 32'h7F7F7F7F);

        check_eq("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/output_peri.md
# output_peri

Store-side counterpart of the switch/button input peripheral. It accepts word-addressed writes from the load-store unit and holds the board output registers: red LEDs, green LEDs, eight 7-segment digits and the character-LCD bus. Writes to the LCD register launch a timed setup/enable/hold strobe sequence. Every register reads back combinationally on the shared 8-bit peripheral address.

## Interface
- SETUP_CYC, 2: cycles the LCD RS/RW/DATA lines are stable before EN rises (≥1)
- PULSE_CYC, 12: cycles EN is held high (≥1)
- HOLD_CYC, 2: cycles the LCD lines are held after EN falls (≥1)
- clk  in  1  system clock; all state on the rising edge
- rst  in  1  reset, synchronous, active-high
- addr  in  8  peripheral byte address; addr[1:0] ignored
- wr_en  in  1  write strobe, one cycle per store
- wmask  in  4  byte enables for wdata
- wdata  in  32  store data
- rdata  out  32  read-back data, combinational from addr
- o_ledr  out  32  red LEDs
- o_ledg  out  32  green LEDs
- o_hex0 … o_hex7  out  7 each  raw segment patterns, active-low
- o_lcd  out  32  {on[31], 20'b0, en[10], rw[9], rs[8], data[7:0]}

## Operation
- Map: 0x00 LEDR; 0x10 LEDG; 0x20 HEX0–3 (byte i → digit i, bits[6:0]); 0x24 HEX4–7; 0x30 LCD cmd {on[31], rw[9], rs[8], data[7:0]}; 0x34 LCD status {overrun[1], busy[0]}.
- Writes: on the clk edge with wr_en=1, update each byte with wmask[i]=1. Unmapped addresses: ignore writes, read 0.
- HEX bit 7 of each byte is not stored and reads 0.
- LCD cmd write with wmask≠0 in IDLE: latch the masked fields and start the strobe FSM.
- LCD cmd write while busy: drop it entirely, leave registers unchanged, set overrun.
- Any write to 0x34 with wmask[0]=1 clears overrun. Busy is read-only.
- FSM states:
  - IDLE: en=0.
  - SETUP: SETUP_CYC cycles, en=0.
  - PULSE: PULSE_CYC cycles, en=1.
  - HOLD: HOLD_CYC cycles, en=0.
  - HOLD returns to IDLE.
- One down-counter, reloaded on each state entry.
- busy = (state≠IDLE).
- o_lcd data, rs, rw and on come straight from the latched cmd register. They are stable for the whole sequence.
- Reset values:
  - LEDR, LEDG: 0.
  - HEX registers and o_hex*: 7'h7F, all segments off (HEX words read 0x7F7F7F7F).
  - LCD cmd: 0; o_lcd = 0.
  - Status: 0.
  - FSM: IDLE.
- rst mid-sequence aborts: en drops to 0 on the reset edge and the FSM returns to IDLE.

## Timing
- Register write at edge N: the output and rdata show the new value from cycle N+1.
- rdata is the same-cycle combinational mux of the current registers.
- LCD cmd accepted at edge N:
  - state=SETUP and busy=1 from N+1.
  - en=1 during cycles N+1+SETUP_CYC … N+SETUP_CYC+PULSE_CYC.
  - busy returns to 0 at N+1+SETUP_CYC+PULSE_CYC+HOLD_CYC. Defaults: 16 busy cycles, 12 with en high.
- A cmd write in the same cycle the FSM re-enters IDLE (busy=0 that cycle) is accepted.
- Simultaneous overrun-set and clear-write in one cycle: set wins.

## Structure
- Package periph_pkg holds:
  - Address constants ADDR_LEDR, ADDR_LEDG, ADDR_HEX_LO, ADDR_HEX_HI, ADDR_LCD, ADDR_LCD_STAT. Shared with input_peri's ADDR_SW and ADDR_BTN.
  - Enum lcd_state_e {LCD_IDLE, LCD_SETUP, LCD_PULSE, LCD_HOLD}.
  - A byte-mask merge function.
- Sub-module lcd_strobe:
  - Inputs: start, SETUP_CYC/PULSE_CYC/HOLD_CYC parameters.
  - Outputs: en, busy.
  - Contains the FSM and counter.
- output_peri owns the register file, decode and read mux.

## Test plan
- Reset, then read all addresses → LEDR=0, LEDG=0, HEX words 0x7F7F7F7F, LCD=0, status=0; o_hex* = 7'h7F.
- Write 0xDEADBEEF to 0x00 with wmask=4'b0101 → o_ledr=0x00AD00EF next cycle; readback matches.
- Write 0x40792430 to 0x20 → o_hex0=7'h30, o_hex1=7'h24, o_hex2=7'h79, o_hex3=7'h40; readback 0x40792430.
- Write 0x80000141 to 0x30 (defaults) → o_lcd data=0x41, rs=1, on=1. en high exactly 12 cycles, starting 3 cycles after the write edge. Status busy=1 for 16 cycles.
- Second cmd write 5 cycles into a sequence → ignored, data stays 0x41, status reads 0x3. Write 0x1 to 0x34 once idle → status 0.
- Assert rst during PULSE → en=0 and busy=0 the next cycle. A new cmd is accepted immediately after rst deasserts. A write to 0x50 reads 0 and changes no output.
